// File: rtl/apb_pkg.sv
// Shared types and sizing helpers for the APB requester bridge.
package apb_pkg;

  // Bridge sequencing: accept, address phase, access phase, hold response.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Upper address bits that select one of up to four slaves.
  localparam int SLV_IDX_WIDTH = 2;

  // Watchdog counter width; kept at least one bit so a disabled watchdog still elaborates.
  function automatic int tmo_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_slv_decode.sv
// Slave index to one-hot PSELx decode, flagging indices with no slave behind them.
module apb_slv_decode
  import apb_pkg::*;
#(
  parameter int SLV_CNT = 4
) (
  input  logic [SLV_IDX_WIDTH-1:0] idx,
  output logic [SLV_CNT-1:0]       sel,
  output logic                     out_of_range
);

  // Walk the populated slaves; anything not matched is a decode error.
  always_comb begin
    sel          = '0;
    out_of_range = 1'b1;
    for (int i = 0; i < SLV_CNT; i++) begin
      if (int'(idx) == i) begin
        sel[i]       = 1'b1;
        out_of_range = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 requester: single-transfer valid/ready request port in, held response out,
// with slave decode and an ACCESS-phase watchdog.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int SLV_ADDR_WIDTH = 8,
  parameter int SLV_CNT        = 4,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT        = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [SLV_CNT-1:0]      PSELx,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERROR
);

  localparam int CNT_W = tmo_cnt_width(TIMEOUT);

  apb_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [DATA_WIDTH/8-1:0] pstrb_q;
  logic [SLV_CNT-1:0]      sel_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;
  logic [CNT_W-1:0]        wait_cnt_q;

  logic                    dec_oor;
  logic [SLV_CNT-1:0]      dec_sel;
  logic                    accept;
  logic                    load_rsp;
  logic                    rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d;
  logic                    tmo_hit;
  logic                    in_bus;

  apb_slv_decode #(
    .SLV_CNT (SLV_CNT)
  ) u_decode (
    .idx          (req_addr[ADDR_WIDTH-1:SLV_ADDR_WIDTH]),
    .sel          (dec_sel),
    .out_of_range (dec_oor)
  );

  // Watchdog fires on the ACCESS cycle that would be the TIMEOUT-th without PREADY.
  always_comb begin
    tmo_hit = 1'b0;
    if (TIMEOUT != 0) begin
      tmo_hit = (int'(wait_cnt_q) >= (TIMEOUT - 1));
    end
  end

  // Next state plus the strobes that load request and response registers.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    load_rsp    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (dec_oor) begin
            state_d   = RESP;
            load_rsp  = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d     = RESP;
          load_rsp    = 1'b1;
          rsp_err_d   = PSLVERROR;
          rsp_rdata_d = (write_q || PSLVERROR) ? '0 : PRDATA;
        end else if (tmo_hit) begin
          state_d   = RESP;
          load_rsp  = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the request for the bus (decode errors leave the bus untouched) and latch the response.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      paddr_q     <= '0;
      write_q     <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      sel_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept && !dec_oor) begin
        paddr_q  <= req_addr;
        write_q  <= req_write;
        pwdata_q <= req_wdata;
        pstrb_q  <= req_write ? req_strb : '0;
        sel_q    <= dec_sel;
      end
      if (load_rsp) begin
        rsp_rdata_q <= rsp_rdata_d;
        rsp_err_q   <= rsp_err_d;
      end
    end
  end

  // Count ACCESS cycles spent waiting; cleared whenever the access phase ends.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_cnt_q <= '0;
    end else if (state_q == ACCESS && state_d == ACCESS) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_q <= '0;
    end
  end

  assign in_bus    = (state_q == SETUP) || (state_q == ACCESS);
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PADDR     = paddr_q;
  assign PSELx     = in_bus ? sel_q : '0;
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = in_bus & write_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: the stimulus process pushes the
// hand-computed response, a negedge monitor pops and compares on each handshake.
module tb_apb_master_bridge;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int SC = 3;
  localparam int TO = 16;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_strb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] PADDR;
  logic [SC-1:0] PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [3:0]    PSTRB;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERROR;

  int   slave_waits = 0;
  logic slave_stuck = 1'b0;
  logic slave_err = 1'b0;
  logic [DW-1:0] slave_rdata = '0;
  int   acc_cnt = 0;

  rsp_t exp_q[$];
  int   checks_total = 0;
  int   checks_passed = 0;

  apb_master_bridge #(
    .DATA_WIDTH     (DW),
    .SLV_ADDR_WIDTH (8),
    .SLV_CNT        (SC),
    .ADDR_WIDTH     (AW),
    .TIMEOUT        (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PSELx     (PSELx),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERROR (PSLVERROR)
  );

  always #5 PCLK = ~PCLK;

  // Simple slave: ready after slave_waits ACCESS cycles unless stuck.
  assign PREADY    = PENABLE && !slave_stuck && (acc_cnt >= slave_waits);
  assign PRDATA    = slave_rdata;
  assign PSLVERROR = PREADY && slave_err;

  always @(posedge PCLK) begin
    if (PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every response handshake must match the oldest expected response.
  always @(negedge PCLK) begin
    rsp_t e;
    if (!PRESET && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks_total++;
        $display("[TB] FAIL rsp_unexpected: got rdata 0x%0h err %0b, expected no response", rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        checkOutput("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  // Issue one request, check the bus phases and the accept-to-response cycle count.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [3:0] strb, input int waits, input logic stuck,
                               input logic serr, input logic [DW-1:0] prdata,
                               input logic [SC-1:0] exp_sel, input logic dec_err,
                               input logic [DW-1:0] exp_rdata, input logic exp_err,
                               input int exp_cycles);
    int cyc;
    slave_waits = waits;
    slave_stuck = stuck;
    slave_err   = serr;
    slave_rdata = prdata;
    checkOutput("req_ready_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    if (dec_err) begin
      checkOutput("dec_rsp_valid", 64'(rsp_valid), 64'(1));
      checkOutput("dec_psel", 64'(PSELx), 64'(0));
      checkOutput("dec_penable", 64'(PENABLE), 64'(0));
    end else begin
      checkOutput("setup_psel", 64'(PSELx), 64'(exp_sel));
      checkOutput("setup_penable", 64'(PENABLE), 64'(0));
      checkOutput("setup_paddr", 64'(PADDR), 64'(addr));
      checkOutput("setup_pwrite", 64'(PWRITE), 64'(wr));
      checkOutput("setup_pstrb", 64'(PSTRB), wr ? 64'(strb) : 64'(0));
      if (wr) checkOutput("setup_pwdata", 64'(PWDATA), 64'(wdata));
      checkOutput("setup_rsp_valid", 64'(rsp_valid), 64'(0));
      @(posedge PCLK); #1;
      checkOutput("access_penable", 64'(PENABLE), 64'(1));
      checkOutput("access_psel", 64'(PSELx), 64'(exp_sel));
      cyc = 0;
      while (cyc < 40) begin
        @(posedge PCLK); #1;
        cyc++;
        if (rsp_valid) break;
        checkOutput("access_paddr_stable", 64'(PADDR), 64'(addr));
      end
      checkOutput("access_cycles", 64'(cyc), 64'(exp_cycles));
      checkOutput("resp_psel", 64'(PSELx), 64'(0));
      checkOutput("resp_penable", 64'(PENABLE), 64'(0));
      checkOutput("resp_pwrite", 64'(PWRITE), 64'(0));
    end
    if (rsp_ready) begin
      @(posedge PCLK); #1;
      checkOutput("back_to_idle", 64'(req_ready), 64'(1));
    end
  endtask

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int n;
    // Reset: everything low except req_ready.
    repeat (2) @(posedge PCLK);
    #1;
    checkOutput("rst_req_ready", 64'(req_ready), 64'(1));
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("rst_psel", 64'(PSELx), 64'(0));
    checkOutput("rst_penable", 64'(PENABLE), 64'(0));
    checkOutput("rst_paddr", 64'(PADDR), 64'(0));
    checkOutput("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Zero-wait write to slave 1; read data must come back as 0.
    applyStimulus(1'b1, 10'h104, 32'hA5A5_0001, 4'hF, 0, 1'b0, 1'b0, 32'h1234_5678,
                  3'b010, 1'b0, 32'h0, 1'b0, 1);
    // Two-wait read from slave 2; strobes forced low.
    applyStimulus(1'b0, 10'h2F0, 32'h0, 4'hF, 2, 1'b0, 1'b0, 32'hDEAD_BEEF,
                  3'b100, 1'b0, 32'hDEAD_BEEF, 1'b0, 3);
    // Read answered with PSLVERROR.
    applyStimulus(1'b0, 10'h0F8, 32'h0, 4'h0, 1, 1'b0, 1'b1, 32'h0BAD_F00D,
                  3'b001, 1'b0, 32'h0, 1'b1, 2);
    // Slave index 3 does not exist.
    applyStimulus(1'b0, 10'h3C0, 32'h0, 4'h0, 0, 1'b0, 1'b0, 32'h1111_2222,
                  3'b000, 1'b1, 32'h0, 1'b1, 0);
    // Slave never ready: watchdog aborts after TIMEOUT access cycles.
    applyStimulus(1'b0, 10'h010, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'h3333_4444,
                  3'b001, 1'b0, 32'h0, 1'b1, 16);
    // PREADY on the same cycle the watchdog would fire: slave response wins.
    applyStimulus(1'b0, 10'h244, 32'h0, 4'h0, 15, 1'b0, 1'b0, 32'hCAFE_0042,
                  3'b100, 1'b0, 32'hCAFE_0042, 1'b0, 16);

    // Back-pressured response: held stable, no new request accepted.
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 10'h180, 32'h0, 4'h0, 0, 1'b0, 1'b0, 32'h1357_9BDF,
                  3'b010, 1'b0, 32'h1357_9BDF, 1'b0, 1);
    slave_rdata = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge PCLK); #1;
      checkOutput("hold_rsp_valid", 64'(rsp_valid), 64'(1));
      checkOutput("hold_req_ready", 64'(req_ready), 64'(0));
      checkOutput("hold_rsp_rdata", 64'(rsp_rdata), 64'(32'h1357_9BDF));
    end
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    checkOutput("hold_release_idle", 64'(req_ready), 64'(1));

    // Reset pulsed during ACCESS: bus idles, no response appears.
    slave_stuck = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 10'h020;
    req_wdata = 32'h7777_8888;
    req_strb  = 4'hF;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    @(posedge PCLK); #1;
    checkOutput("abort_in_access", 64'(PENABLE), 64'(1));
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    checkOutput("abort_psel", 64'(PSELx), 64'(0));
    checkOutput("abort_penable", 64'(PENABLE), 64'(0));
    checkOutput("abort_pwrite", 64'(PWRITE), 64'(0));
    checkOutput("abort_req_ready", 64'(req_ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK); #1;
      checkOutput("abort_no_rsp", 64'(rsp_valid), 64'(0));
    end
    slave_stuck = 1'b0;

    // Recovery: partial-strobe write after the abort.
    applyStimulus(1'b1, 10'h0AC, 32'h0102_0304, 4'b0011, 0, 1'b0, 1'b0, 32'h9999_AAAA,
                  3'b001, 1'b0, 32'h0, 1'b0, 1);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge PCLK); #1;
      n++;
    end
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
